// File: rtl/bitgen_pkg.sv
// Shared types and constants for the serial bit stream generator.
package bitgen_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned PRBS_W      = 7;
   localparam int unsigned MIN_PERIOD  = 2;
   localparam int unsigned PRBS7_TAP_A = 6;
   localparam int unsigned PRBS7_TAP_B = 5;

   localparam logic [PRBS_W-1:0] PRBS7_SEED = 7'h7F;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2
   } state_t;

   // One PRBS7 step, x^7 + x^6 + 1, shifting toward the msb.
   function automatic logic [PRBS_W-1:0] prbs7_step(input logic [PRBS_W-1:0] s);
      return {s[PRBS_W-2:0], s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B]};
   endfunction

endpackage

// File: rtl/bit_stream_gen_if.sv
// Byte handshake between a byte source and the serial transmitter.
interface bit_stream_gen_if;
   import bitgen_pkg::*;

   logic [BYTE_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/bit_stream_gen_bit_timer.sv
// Bit period counter: period latch and clamp, end-of-bit strobe, reference clock.
module bit_timer
   import bitgen_pkg::*;
#(
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk_200M,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] bit_period,
   output logic                bit_strobe,
   output logic                bit_start,
   output logic                clk_ref
);

   localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

   logic [PERIOD_W-1:0] cnt_q;
   logic [PERIOD_W-1:0] per_q;
   logic                running_q;
   logic [PERIOD_W-1:0] p_clamp;
   logic [PERIOD_W-1:0] per_n;
   logic [PERIOD_W-1:0] cnt_n;

   // A new bit begins on the first enabled cycle and after every strobe.
   assign bit_start = enable && (!running_q || bit_strobe);

   // Next counter value and the period that applies to it.
   always_comb begin
      p_clamp = (bit_period < P_MIN) ? P_MIN : bit_period;
      per_n   = per_q;
      cnt_n   = cnt_q + ONE;
      if (bit_start) begin
         per_n = p_clamp;
         cnt_n = '0;
      end
   end

   // Counter and registered decodes, aligned with the counter value they describe.
   always_ff @(posedge clk_200M or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         per_q      <= P_MIN;
         running_q  <= 1'b0;
         bit_strobe <= 1'b0;
         clk_ref    <= 1'b0;
      end else if (!enable) begin
         cnt_q      <= '0;
         running_q  <= 1'b0;
         bit_strobe <= 1'b0;
         clk_ref    <= 1'b0;
      end else begin
         cnt_q      <= cnt_n;
         per_q      <= per_n;
         running_q  <= 1'b1;
         bit_strobe <= (cnt_n == (per_n - ONE));
         clk_ref    <= (cnt_n < (per_n >> 1));
      end
   end

endmodule

// File: rtl/bit_stream_gen.sv
// Serial NRZ transmitter: preamble-framed bytes, PRBS7 idle fill, reference bit clock.
module bit_stream_gen
   import bitgen_pkg::*;
#(
   parameter int unsigned PERIOD_W      = 16,
   parameter int unsigned PREAMBLE_BITS = 16,
   parameter int unsigned IDLE_PRBS     = 1
) (
   input  logic                clk_200M,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] bit_period,
   bit_stream_gen_if.slave     tx,
   output logic                signal_out,
   output logic                clk_ref,
   output logic                bit_strobe,
   output logic                busy
);

   localparam int unsigned     PRE_W    = $clog2(PREAMBLE_BITS);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);
   localparam bit              USE_PRBS = (IDLE_PRBS != 0);

   state_t              state_q, state_n;
   logic [2:0]          bit_idx_q, bit_idx_n;
   logic [PRE_W-1:0]    pre_idx_q, pre_idx_n, pre_inc;
   logic [BYTE_W-1:0]   shreg_q, shreg_n;
   logic [PRBS_W-1:0]   prbs_q, prbs_n;
   logic                sig_n;
   logic                bit_start;
   logic                xfer;

   bit_timer #(.PERIOD_W(PERIOD_W)) u_bit_timer (
      .clk_200M   (clk_200M),
      .rst_n      (rst_n),
      .enable     (enable),
      .bit_period (bit_period),
      .bit_strobe (bit_strobe),
      .bit_start  (bit_start),
      .clk_ref    (clk_ref)
   );

   // Bytes are only taken on the last cycle of an idle bit or of data bit 7.
   assign tx.tx_ready = enable && bit_strobe &&
                        ((state_q == IDLE) || ((state_q == DATA) && (bit_idx_q == 3'd7)));
   assign xfer = tx.tx_valid && tx.tx_ready;
   assign pre_inc = pre_idx_q + PRE_W'(1);

   // Next state and next line bit, evaluated at each bit boundary.
   always_comb begin
      state_n   = state_q;
      bit_idx_n = bit_idx_q;
      pre_idx_n = pre_idx_q;
      shreg_n   = shreg_q;
      prbs_n    = prbs_q;
      sig_n     = signal_out;
      if (!enable) begin
         state_n   = IDLE;
         bit_idx_n = 3'd0;
         pre_idx_n = '0;
         sig_n     = 1'b0;
      end else if (bit_start) begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  state_n   = PREAMBLE;
                  pre_idx_n = '0;
                  shreg_n   = tx.tx_data;
                  sig_n     = 1'b1;
               end else begin
                  sig_n = USE_PRBS ? prbs_q[PRBS_W-1] : 1'b0;
                  if (USE_PRBS) prbs_n = prbs7_step(prbs_q);
               end
            end
            PREAMBLE: begin
               if (pre_idx_q == PRE_LAST) begin
                  state_n   = DATA;
                  bit_idx_n = 3'd0;
                  sig_n     = shreg_q[BYTE_W-1];
                  shreg_n   = {shreg_q[BYTE_W-2:0], 1'b0};
               end else begin
                  pre_idx_n = pre_inc;
                  sig_n     = ~pre_inc[0];
               end
            end
            DATA: begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_n = 3'd0;
                  if (xfer) begin
                     sig_n   = tx.tx_data[BYTE_W-1];
                     shreg_n = {tx.tx_data[BYTE_W-2:0], 1'b0};
                  end else begin
                     state_n = IDLE;
                     sig_n   = USE_PRBS ? prbs_q[PRBS_W-1] : 1'b0;
                     if (USE_PRBS) prbs_n = prbs7_step(prbs_q);
                  end
               end else begin
                  bit_idx_n = bit_idx_q + 3'd1;
                  sig_n     = shreg_q[BYTE_W-1];
                  shreg_n   = {shreg_q[BYTE_W-2:0], 1'b0};
               end
            end
            default: begin
               state_n = IDLE;
               sig_n   = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and registered line outputs.
   always_ff @(posedge clk_200M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_idx_q  <= 3'd0;
         pre_idx_q  <= '0;
         shreg_q    <= '0;
         prbs_q     <= PRBS7_SEED;
         signal_out <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_n;
         bit_idx_q  <= bit_idx_n;
         pre_idx_q  <= pre_idx_n;
         shreg_q    <= shreg_n;
         prbs_q     <= prbs_n;
         signal_out <= sig_n;
         busy       <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_bit_stream_gen.sv
// Directed, table-driven bench for bit_stream_gen.
module tb_bit_stream_gen;

   typedef struct {
      int unsigned per;
      int unsigned n_offer;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        sig;
      logic        bsy;
      logic        rdy;
   } vec_t;

   logic        clk_200M = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] bit_period;
   logic        signal_out;
   logic        clk_ref;
   logic        bit_strobe;
   logic        busy;

   vec_t        tbl[$];
   logic [7:0]  pend[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [0:25] pr;

   bit_stream_gen_if tx_if ();

   bit_stream_gen #(.PERIOD_W(16), .PREAMBLE_BITS(16), .IDLE_PRBS(1)) dut (
      .clk_200M   (clk_200M),
      .rst_n      (rst_n),
      .enable     (enable),
      .bit_period (bit_period),
      .tx         (tx_if.slave),
      .signal_out (signal_out),
      .clk_ref    (clk_ref),
      .bit_strobe (bit_strobe),
      .busy       (busy)
   );

   always #5 clk_200M = ~clk_200M;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(input int unsigned per, input logic sig, input logic bsy,
                               input logic rdy, input int unsigned n, input logic [7:0] d0,
                               input logic [7:0] d1);
      vec_t v;
      v.per = per; v.sig = sig; v.bsy = bsy; v.rdy = rdy;
      v.n_offer = n; v.d0 = d0; v.d1 = d1;
      tbl.push_back(v);
   endfunction

   function automatic void add_pre(input int unsigned per);
      for (int i = 0; i < 16; i++) add(per, (i % 2) == 0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
   endfunction

   function automatic void add_byte(input int unsigned per, input logic [7:0] b, input int nbits);
      logic [7:0] bb;
      bb = b;
      for (int i = 0; i < nbits; i++) add(per, bb[7-i], 1'b1, i == 7, 0, 8'h00, 8'h00);
   endfunction

   function automatic int unsigned eff_of(input int unsigned per);
      return (per < 2) ? 2 : per;
   endfunction

   // Checks ncyc cycles of one bit; offers bytes and sets the next bit's period on cycle 0.
   task automatic run_bit(input vec_t v, input int unsigned next_per, input int unsigned ncyc,
                          input string tag);
      int unsigned eff;
      logic        last;
      eff = eff_of(v.per);
      for (int unsigned c = 0; c < ncyc; c++) begin
         @(negedge clk_200M);
         if (c == 0) begin
            bit_period = 16'(next_per);
            if (v.n_offer > 0) pend.push_back(v.d0);
            if (v.n_offer > 1) pend.push_back(v.d1);
            if (!tx_if.tx_valid && pend.size() > 0) begin
               tx_if.tx_data  = pend.pop_front();
               tx_if.tx_valid = 1'b1;
            end
         end
         last = (c == eff - 1);
         chk({tag, ".sig"},    signal_out,      v.sig);
         chk({tag, ".busy"},   busy,            v.bsy);
         chk({tag, ".clkref"}, clk_ref,         c < (eff >> 1));
         chk({tag, ".strobe"}, bit_strobe,      last);
         chk({tag, ".ready"},  tx_if.tx_ready,  last ? v.rdy : 1'b0);
         if (last && tx_if.tx_ready && tx_if.tx_valid) begin
            @(posedge clk_200M);
            #1;
            if (pend.size() > 0) tx_if.tx_data = pend.pop_front();
            else                 tx_if.tx_valid = 1'b0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".sig"},    signal_out,     1'b0);
      chk({tag, ".busy"},   busy,           1'b0);
      chk({tag, ".clkref"}, clk_ref,        1'b0);
      chk({tag, ".strobe"}, bit_strobe,     1'b0);
      chk({tag, ".ready"},  tx_if.tx_ready, 1'b0);
   endtask

   task automatic run_list(input vec_t l[$], input string pfx);
      for (int i = 0; i < l.size(); i++)
         run_bit(l[i], (i + 1 < l.size()) ? l[i+1].per : l[i].per, eff_of(l[i].per),
                 $sformatf("%s%0d", pfx, i));
   endtask

   initial begin
      vec_t tail[$];
      vec_t v;
      // PRBS7 from seed 7F, msb first, bits 0..25
      pr = 26'b11111110000001000001100001;
      rst_n = 1'b0; enable = 1'b0; bit_period = 16'd8;
      tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;

      repeat (3) @(negedge clk_200M);
      chk_zero("reset");

      // Idle PRBS at P=8
      for (int i = 0; i < 8; i++) add(8, pr[i], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      // Single framed byte A5 at P=10
      add(10, pr[8], 1'b0, 1'b1, 1, 8'hA5, 8'h00);
      add_pre(10);
      add_byte(10, 8'hA5, 8);
      add(10, pr[9], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      // Back-to-back FF, 00 with valid held
      add(10, pr[10], 1'b0, 1'b1, 2, 8'hFF, 8'h00);
      add_pre(10);
      add_byte(10, 8'hFF, 8);
      add_byte(10, 8'h00, 8);
      for (int i = 11; i <= 14; i++) add(10, pr[i], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      // Period clamp and odd period
      add(0, pr[15], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(0, pr[16], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(1, pr[17], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(1, pr[18], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(7, pr[19], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(7, pr[20], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      // Frame 3C at P=4, interrupted later in data bit 3
      add(4, pr[21], 1'b0, 1'b1, 1, 8'h3C, 8'h00);
      add_pre(4);
      add_byte(4, 8'h3C, 3);

      @(negedge clk_200M);
      bit_period = 16'(tbl[0].per);
      enable = 1'b1;
      rst_n  = 1'b1;
      run_list(tbl, "b");

      // Data bit 3 of 3C is a 1; drop enable partway through it
      v.per = 4; v.n_offer = 0; v.d0 = 8'h00; v.d1 = 8'h00; v.sig = 1'b1; v.bsy = 1'b1; v.rdy = 1'b0;
      run_bit(v, 4, 2, "d3");
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_200M);
         chk_zero($sformatf("dis%0d", i));
      end
      enable = 1'b1;

      // Idle fill resumes from the held PRBS state, then a frame cut by reset
      tbl.delete();
      for (int i = 22; i <= 24; i++) add(4, pr[i], 1'b0, 1'b1, 0, 8'h00, 8'h00);
      add(4, pr[25], 1'b0, 1'b1, 1, 8'h81, 8'h00);
      add(4, 1'b1, 1'b1, 1'b0, 0, 8'h00, 8'h00);
      add(4, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00);
      run_list(tbl, "re");
      v.per = 4; v.sig = 1'b1; v.bsy = 1'b1; v.rdy = 1'b0;
      run_bit(v, 4, 2, "p2");
      rst_n = 1'b0;
      #1;
      chk_zero("rst_async");
      @(negedge clk_200M);
      chk_zero("rst_hold");
      rst_n = 1'b1;

      // First idle bits after reset come from the seed again
      for (int i = 0; i < 3; i++) begin
         v.per = 4; v.sig = pr[i]; v.bsy = 1'b0; v.rdy = 1'b1;
         tail.push_back(v);
      end
      run_list(tail, "post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net against a stuck run
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
